mul_dispatch: RTL and testbench
===============================

# mul_dispatch

Request-dispatch stage directly upstream of the combinational 8-bit `MUL` unit in the multiprocessor datapath. Accepts multiply requests from two cores over valid/ready handshakes and arbitrates them round-robin into a small FIFO. Drives the operands into `MUL` one request at a time, registers its `result`, and returns it to the issuing core tagged with that core's id.

## Interface
- `WIDTH`, 8: operand and result width; must equal the `MUL` width.
- `DEPTH`, 4: request FIFO entries; power of two, ≥ 2.

- `clk`  in  1  sole clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  core 0 / core 1 request present.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_ready`, `req1_ready`  out  1  grant; a request is accepted on an edge where valid && ready.
- `mul_a`, `mul_b`  out  WIDTH  operands to `MUL` (`a`, `b`), registered.
- `mul_result`  in  WIDTH  `MUL` `result`, combinational from `mul_a`/`mul_b`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  WIDTH  product, low WIDTH bits.
- `rsp_id`  out  1  issuing core (0/1).

## Operation
- **FIFO.** Entries are {id, a, b}, with read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Arbiter.**
  - It is combinational and grants only when count < DEPTH. Capacity freed by a pop in the same cycle does not count.
  - Only one requester is valid: that one is granted.
  - Both are valid: the core not granted last is granted. The last-grant flag resets to 1, so core 0 wins the first tie.
  - The ungranted ready is 0. The last-grant flag updates only on an accepted push.
  - While `rst_n` is low, both readies are 0.
- **Execute FSM**, states IDLE, CALC, RESP:
  - IDLE: if count > 0, pop the head into `mul_a`/`mul_b`/id register and go to CALC.
  - CALC: capture `mul_result` into `rsp_result`, go to RESP.
  - RESP: `rsp_valid`=1. Hold `rsp_result`/`rsp_id` stable until `rsp_ready`.
  - RESP with a handshake: if count > 0, pop the next entry and go to CALC (back-to-back); otherwise go to IDLE.
- **Simultaneous events.** Push and pop in the same cycle are both performed and count is unchanged. A request arriving into an empty FIFO is not bypassed; it is popped on the next edge.
- **Arithmetic.** No saturation; the result is `MUL` output truncated to WIDTH. Example: 15×20 = 300 → 44.
- **Reset.** Asserting `rst_n` mid-operation discards all FIFO contents and any in-flight response immediately. Nothing is replayed.

## Timing
- **Reset values:** `req*_ready`=0, `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, FSM=IDLE, count=0, pointers=0, last-grant=1.
- **Latency with the FIFO empty and the FSM in IDLE:**
  - Edge E: request accepted.
  - Edge E+1: popped; operands appear on `mul_a`/`mul_b`.
  - Edge E+2: result captured.
  - `rsp_valid` is high from after E+2.
  - Minimum latency is 2 cycles from accept to `rsp_valid`.
- **Throughput:** one response per 2 cycles with `rsp_ready` tied high (CALC and RESP alternate).
- **Backpressure:** with `rsp_ready` low, the FIFO fills. Readies then drop while count = DEPTH, and resume the cycle after a pop.
- **Settling:** `MUL` must settle within one cycle. `mul_a`/`mul_b` change only on pop edges.

## Test plan
- **Reset and single request:** hold `rst_n` low 3 cycles and check all reset values. Then core 0 sends a=3, b=4 → `rsp_valid` 2 cycles after accept with `rsp_result`=12, `rsp_id`=0.
- **Tie arbitration:** both cores valid every cycle, core 0 (15,2), core 1 (10,10) → grants alternate 0,1,0,1… and responses alternate 30/id0, 100/id1, in order.
- **Backpressure and full:** `rsp_ready`=0, core 1 streams 6 requests → exactly DEPTH+1=5 accepted (4 in the FIFO, 1 in RESP), then `req1_ready`=0. Raise `rsp_ready` → all 5 results return in order, and the 6th request is accepted the cycle after the first pop.
- **Truncation:** a=15, b=20 → 44. a=255, b=255 → 1.
- **Response stability:** hold `rsp_ready`=0 for 5 cycles in RESP while new requests arrive → `rsp_result`/`rsp_id` unchanged. Then release and check back-to-back CALC with no IDLE cycle.
- **Mid-operation reset:** pulse `rst_n` low asynchronously (between edges) with 3 entries queued → outputs return to reset values immediately. After release, a new request (7×6) returns 42 as the first response.

Source files
------------

// File: rtl/mul_dispatch.sv
// ============================================================================
// mul_dispatch
//   Two-core round-robin request dispatcher in front of a combinational MUL
//   unit: request FIFO, one-at-a-time execute FSM, tagged response port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mul_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [WIDTH-1:0] fifo_a_q  [DEPTH];
  logic [WIDTH-1:0] fifo_b_q  [DEPTH];
  logic             fifo_id_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             last_q;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mul_a_q, mul_b_q;
  logic             id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_id_q;

  logic grant0, grant1, push, pop, not_full, has_data;

  // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    not_full = (count_q != CW'(DEPTH));
    has_data = (count_q != '0);
    grant0   = rst_n && not_full && req0_valid && (!req1_valid || last_q);
    grant1   = rst_n && not_full && req1_valid && (!req0_valid || !last_q);
    push     = grant0 | grant1;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (has_data) begin
          pop     = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          if (has_data) begin
            pop     = 1'b1;
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q]  <= grant1 ? req1_a : req0_a;
      fifo_b_q[wr_ptr_q]  <= grant1 ? req1_b : req0_b;
      fifo_id_q[wr_ptr_q] <= grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_q       <= 1'b1;
      state_q      <= S_IDLE;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        last_q   <= grant1;
      end
      if (pop) begin
        mul_a_q  <= fifo_a_q[rd_ptr_q];
        mul_b_q  <= fifo_b_q[rd_ptr_q];
        id_q     <= fifo_id_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (state_q == S_CALC) begin
        rsp_result_q <= mul_result;
        rsp_id_q     <= id_q;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_dispatch.sv
// ============================================================================
// tb_mul_dispatch
//   Directed self-checking bench for mul_dispatch with a behavioural MUL.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_dispatch;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [WIDTH-1:0] mul_a, mul_b, mul_result;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural MUL: product truncated to WIDTH by the assignment context.
  assign mul_result = mul_a * mul_b;

  mul_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with rsp_ready high; consumes one response.
  task automatic wait_rsp(input string tag, input logic [7:0] er, input logic ei);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_res"}, 32'(rsp_result), 32'(er));
    chk({tag, "_id"}, 32'(rsp_id), 32'(ei));
    @(negedge clk);
  endtask

  task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b);
    if (!id) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    #1;
    chk("send_ready", 32'(id ? req1_ready : req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic       q[$];
    logic       nxt;
    logic       eid;
    logic       quiet;
    int         grants;
    int         k;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;

    // Reset values, with both cores requesting during reset
    repeat (3) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single request, latency 2
    @(negedge clk);
    send(1'b0, 8'd3, 8'd4);
    chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_mul_a", 32'(mul_a), 32'd3);
    chk("lat_mul_b", 32'(mul_b), 32'd4);
    chk("lat_e1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_e2_valid", 32'(rsp_valid), 32'd1);
    chk("lat_res", 32'(rsp_result), 32'd12);
    chk("lat_id", 32'(rsp_id), 32'd0);
    @(negedge clk);

    // Tie arbitration from a fresh reset: core 0 first, then alternate
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    nxt = 1'b0;
    grants = 0;
    req0_a = 8'd15; req0_b = 8'd2; req1_a = 8'd10; req1_b = 8'd10;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("tie_extra_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          eid = q.pop_front();
          chk("tie_rsp_id", 32'(rsp_id), 32'(eid));
          chk("tie_rsp_res", 32'(rsp_result), eid ? 32'd100 : 32'd30);
        end
      end
      req0_valid = (c < 8);
      req1_valid = (c < 8);
      #1;
      if (req0_ready || req1_ready) begin
        chk("tie_grant0", 32'(req0_ready), 32'(!nxt));
        chk("tie_grant1", 32'(req1_ready), 32'(nxt));
        q.push_back(nxt);
        nxt = !nxt;
        grants++;
      end
      @(negedge clk);
    end
    chk("tie_grants", 32'(grants), 32'd7);
    chk("tie_leftover", 32'(q.size()), 32'd0);

    // Backpressure: DEPTH+1 accepted, then ready drops until the first pop
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      req1_valid = (k < 6);
      req1_a = 8'(10 + k);
      req1_b = 8'd3;
      #1;
      if (req1_ready) k++;
      @(negedge clk);
    end
    #1;
    chk("bp_accepted", 32'(k), 32'd5);
    chk("bp_full_ready", 32'(req1_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp0_res", 32'(rsp_result), 32'd30);
    chk("bp_rsp0_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_calc_valid", 32'(rsp_valid), 32'd0);
    chk("bp_resume_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    for (int r = 1; r < 6; r++) wait_rsp("bp_rsp", 8'((10 + r) * 3), 1'b1);

    // Truncation
    send(1'b0, 8'd15, 8'd20);
    wait_rsp("trunc_15x20", 8'd44, 1'b0);
    send(1'b1, 8'd255, 8'd255);
    wait_rsp("trunc_255x255", 8'd1, 1'b1);

    // Response stability under backpressure, then back-to-back CALC
    rsp_ready = 1'b0;
    send(1'b0, 8'd9, 8'd9);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk("stab_valid", 32'(rsp_valid), 32'd1);
      chk("stab_res", 32'(rsp_result), 32'd81);
      chk("stab_id", 32'(rsp_id), 32'd0);
      if (j < 4) begin
        req1_valid = 1'b1; req1_a = 8'(2 + j); req1_b = 8'd5;
        #1;
        chk("stab_ready", 32'(req1_ready), 32'd1);
      end else begin
        req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_calc_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_mul_a", 32'(mul_a), 32'd2);
    for (int r = 0; r < 4; r++) wait_rsp("b2b_rsp", 8'((2 + r) * 5), 1'b1);

    // Asynchronous reset with entries queued and a response pending
    rsp_ready = 1'b0;
    send(1'b0, 8'd5, 8'd5);
    send(1'b0, 8'd6, 8'd6);
    send(1'b0, 8'd7, 8'd7);
    send(1'b0, 8'd8, 8'd8);
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd6;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_mul_a", 32'(mul_a), 32'd0);
    chk("mid_mul_b", 32'(mul_b), 32'd0);
    chk("mid_rsp_result", 32'(rsp_result), 32'd0);
    chk("mid_ready0", 32'(req0_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("mid_post_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp("mid_new", 8'd42, 1'b0);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) quiet = 1'b0;
      @(negedge clk);
    end
    chk("mid_no_replay", 32'(quiet), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
